param_universal_reg: RTL and testbench

- Parametrised successor to the single-bit D flip-flop with clear: a WIDTH-bit register with clear, enable and eight operating modes.
- Modes: hold, parallel load, shift, rotate, and up/down count.
- Provides registered serial-out and count-wrap status.
- Building block for the team's counter, shifter and sequencer designs; replaces ad-hoc banks of single flip-flops.

---
 rtl/param_universal_reg.sv | 72 +++++++
 tb/tb_param_universal_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/param_universal_reg.sv
// WIDTH-bit universal register: synchronous clear, enable, and eight modes
// (hold, load, shift, rotate, count), with registered shift-out and wrap pulse.
module param_universal_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLOCK,
    input  logic             CLEAR,
    input  logic             ENABLE,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             SERIAL_IN_LSB,
    input  logic             SERIAL_IN_MSB,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             SHIFT_OUT,
    output logic             WRAP
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_UP   = 3'b110;
    localparam logic [2:0] M_DN   = 3'b111;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // WRAP defaults low on every non-clear edge so it can only ever be a
    // single-cycle pulse; SHIFT_OUT is only touched by the shift/rotate modes.
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            OUTPUT    <= RESET_VALUE;
            SHIFT_OUT <= 1'b0;
            WRAP      <= 1'b0;
        end else if (!ENABLE) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= 1'b0;
            case (MODE)
                M_HOLD: ;
                M_LOAD: OUTPUT <= DATA_IN;
                M_SHL: begin
                    OUTPUT    <= {OUTPUT[WIDTH-2:0], SERIAL_IN_LSB};
                    SHIFT_OUT <= OUTPUT[WIDTH-1];
                end
                M_SHR: begin
                    OUTPUT    <= {SERIAL_IN_MSB, OUTPUT[WIDTH-1:1]};
                    SHIFT_OUT <= OUTPUT[0];
                end
                M_ROL: begin
                    OUTPUT    <= {OUTPUT[WIDTH-2:0], OUTPUT[WIDTH-1]};
                    SHIFT_OUT <= OUTPUT[WIDTH-1];
                end
                M_ROR: begin
                    OUTPUT    <= {OUTPUT[0], OUTPUT[WIDTH-1:1]};
                    SHIFT_OUT <= OUTPUT[0];
                end
                M_UP: begin
                    OUTPUT <= OUTPUT + ONE;
                    WRAP   <= &OUTPUT;
                end
                M_DN: begin
                    OUTPUT <= OUTPUT - ONE;
                    WRAP   <= ~|OUTPUT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_universal_reg.sv
// Scoreboard bench for param_universal_reg (WIDTH=4): directed test plan
// followed by random stimulus checked against an arithmetic reference model.
module tb_param_universal_reg;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         en  = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] din = '0;
    logic         sl = 1'b0;
    logic         sm = 1'b0;
    logic [W-1:0] out;
    logic         so;
    logic         wr;

    param_universal_reg #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .CLOCK(clk), .CLEAR(clr), .ENABLE(en), .MODE(mode), .DATA_IN(din),
        .SERIAL_IN_LSB(sl), .SERIAL_IN_MSB(sm),
        .OUTPUT(out), .SHIFT_OUT(so), .WRAP(wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int s;
        int w;
        int n;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   nstep  = 0;

    // Reference state, held as plain integers.
    int  mq = 0, ms = 0, mw = 0;
    bit  mvalid = 1'b0;

    // Monitor: DUT presents a new result after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (int'(out) != e.q) begin
                errors++;
                $display("FAIL output step %0d: got %0d want %0d", e.n, out, e.q);
            end
            checks++;
            if (int'(so) != e.s) begin
                errors++;
                $display("FAIL shift_out step %0d: got %0d want %0d", e.n, so, e.s);
            end
            checks++;
            if (int'(wr) != e.w) begin
                errors++;
                $display("FAIL wrap step %0d: got %0d want %0d", e.n, wr, e.w);
            end
        end
    end

    task automatic step(input bit c, input bit e, input int md, input int d,
                        input bit l, input bit h);
        exp_t x;
        @(negedge clk);
        clr = c; en = e; mode = md[2:0]; din = d[W-1:0]; sl = l; sm = h;
        // Inputs changed mid-cycle must not reach the outputs before the edge.
        #1;
        if (mvalid) begin
            checks++;
            if (int'(out) != mq || int'(so) != ms || int'(wr) != mw) begin
                errors++;
                $display("FAIL midcycle step %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         nstep, out, so, wr, mq, ms, mw);
            end
        end
        if (c) begin
            mq = 0; ms = 0; mw = 0; mvalid = 1'b1;
        end else begin
            mw = 0;
            if (e) begin
                case (md)
                    1: mq = d % M;
                    2: begin ms = mq / (M/2); mq = (mq * 2 + int'(l)) % M; end
                    3: begin ms = mq % 2; mq = mq / 2 + int'(h) * (M/2); end
                    4: begin ms = mq / (M/2); mq = (mq * 2) % M + mq / (M/2); end
                    5: begin ms = mq % 2; mq = mq / 2 + (mq % 2) * (M/2); end
                    6: begin mw = (mq == M-1); mq = (mq + 1) % M; end
                    7: begin mw = (mq == 0); mq = (mq + M - 1) % M; end
                    default: ;
                endcase
            end
        end
        x.q = mq; x.s = ms; x.w = mw; x.n = nstep;
        sb.push_back(x);
        nstep++;
    endtask

    initial begin
        // 1. reset timing
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 4'b0101, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // 2. shift left / right
        step(0, 1, 1, 4'b1011, 0, 0);
        step(0, 1, 2, 0, 0, 0);
        step(0, 1, 2, 0, 0, 0);
        step(0, 1, 3, 0, 0, 1);
        // 3. rotate, then load keeps SHIFT_OUT
        step(0, 1, 1, 4'b1011, 0, 0);
        step(0, 1, 5, 0, 0, 0);
        step(0, 1, 4, 0, 0, 0);
        step(0, 1, 1, 4'b0000, 0, 0);
        // 4. count up through wrap
        step(0, 1, 1, 4'b1110, 0, 0);
        step(0, 1, 6, 0, 0, 0);
        step(0, 1, 6, 0, 0, 0);
        step(0, 1, 6, 0, 0, 0);
        // 5. count down through wrap
        step(0, 1, 1, 4'b0000, 0, 0);
        step(0, 1, 7, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0);
        // consecutive wraps: up from 1111, down from 0000, up again
        step(0, 1, 1, 4'b1111, 0, 0);
        step(0, 1, 6, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0);
        step(0, 1, 6, 0, 0, 0);
        step(0, 0, 6, 0, 0, 0);
        // 6. priority
        step(0, 1, 1, 4'b0101, 0, 0);
        step(0, 0, 1, 4'b1010, 0, 0);
        step(1, 1, 1, 4'b1010, 0, 0);
        step(0, 1, 1, 4'b0110, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // random phase
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 7), $urandom_range(0, M-1),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
